// File: rtl/i_divide_pkg.sv
// rtl/i_divide_pkg.sv - shared CPU definitions: word size, divide opcodes, divider state enum
package i_divide_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    // Divide flavour as carried on is_signed
    localparam logic DIV_OP_UDIV = 1'b0;
    localparam logic DIV_OP_SDIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/i_divide_if.sv
// rtl/i_divide_if.sv - request/result bundle between decode/writeback and the divider
interface i_divide_if #(parameter int WIDTH = i_divide_pkg::WORD);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/i_divide_div_step.sv
// rtl/i_divide_div_step.sv - one combinational radix-2 restoring division step
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] part_rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH-1:0] new_rem,
    output logic             quo_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Shift in the next dividend bit and try subtracting; part_rem < divisor keeps
    // the shifted value below 2^(WIDTH+1), so the top bit of trial is the borrow.
    always_comb begin
        shifted = {part_rem, next_bit};
        trial   = shifted - {1'b0, divisor};
        quo_bit = ~trial[WIDTH];
        new_rem = quo_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/i_divide.sv
// rtl/i_divide.sv - multi-cycle signed/unsigned integer divider with zero-divisor bypass
module i_divide
    import i_divide_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int CNT_W = 7
) (
    input  logic       clk,
    input  logic       reset,
    i_divide_if.slave  bus
);

    div_state_t       state;
    div_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] dvs_mag;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dz_r;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             divisor_zero;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] final_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             last_step;

    // Operand magnitudes; negating the most-negative value yields 2^(WIDTH-1) as unsigned
    always_comb begin
        dividend_neg = bus.is_signed & bus.dividend[WIDTH-1];
        divisor_neg  = bus.is_signed & bus.divisor[WIDTH-1];
        dividend_mag = dividend_neg ? -bus.dividend : bus.dividend;
        divisor_mag  = divisor_neg  ? -bus.divisor  : bus.divisor;
        divisor_zero = (bus.divisor == '0);
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .part_rem (part_rem),
        .divisor  (dvs_mag),
        .next_bit (shift_q[WIDTH-1]),
        .new_rem  (step_rem),
        .quo_bit  (step_q)
    );

    // Dividend bits leave shift_q at the top while quotient bits enter at the bottom;
    // the final signs are applied to the result of the last step
    always_comb begin
        final_q   = {shift_q[WIDTH-2:0], step_q};
        res_q     = neg_q ? -final_q : final_q;
        res_r     = neg_r ? -step_rem : step_rem;
        last_step = (cnt == CNT_W'(1));
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = divisor_zero ? DONE : BUSY;
            BUSY:    if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration, and result registers updated only on entry to DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            part_rem    <= '0;
            shift_q     <= '0;
            dvs_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dz_r        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (divisor_zero) begin
                            quotient_r  <= '0;
                            remainder_r <= bus.dividend;
                            dz_r        <= 1'b1;
                        end else begin
                            part_rem <= '0;
                            shift_q  <= dividend_mag;
                            dvs_mag  <= divisor_mag;
                            neg_q    <= dividend_neg ^ divisor_neg;
                            neg_r    <= dividend_neg;
                            cnt      <= CNT_W'(WIDTH);
                        end
                    end
                end
                BUSY: begin
                    part_rem <= step_rem;
                    shift_q  <= final_q;
                    cnt      <= cnt - CNT_W'(1);
                    if (last_step) begin
                        quotient_r  <= res_q;
                        remainder_r <= res_r;
                        dz_r        <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status and result outputs
    always_comb begin
        bus.busy        = (state == BUSY);
        bus.done        = (state == DONE);
        bus.quotient    = quotient_r;
        bus.remainder   = remainder_r;
        bus.div_by_zero = dz_r;
    end

endmodule

// File: tb/tb_i_divide.sv
// tb/tb_i_divide.sv - scoreboard bench for i_divide
module tb_i_divide;

    localparam int W = 64;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    i_divide_if #(.WIDTH(W)) bus ();

    i_divide #(.WIDTH(W), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        if (b == '0) begin
            e.q = '0; e.r = a; e.dz = 1'b1;
        end else if (!s) begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end else if (a == MIN_NEG && b == {W{1'b1}}) begin
            e.q = MIN_NEG; e.r = '0; e.dz = 1'b0;
        end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                               input logic push);
        if (push) sb.push_back(model(a, b, s));
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = s;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // Waits for done (lat already counts the start edge), then checks latency, busy count and result
    task automatic finish_op(input string name, input int exp_lat, input int lat_in);
        int   lat;
        int   busy_cnt;
        exp_t e;
        lat = lat_in;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < W + 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, bus.done, lat);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        if (lat_in == 1) begin
            checks++;
            if (busy_cnt !== exp_lat - 1) begin
                errors++;
                $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, exp_lat - 1);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b required 0", name, bus.busy);
        end
        e = sb.pop_front();
        checks++;
        if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dz) begin
            errors++;
            $display("FAIL %s result: got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                     name, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dz);
        end
        tick();
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.quotient !== e.q || bus.remainder !== e.r ||
            bus.div_by_zero !== e.dz) begin
            errors++;
            $display("FAIL %s hold: got done=%b q=%h r=%h dz=%b required done=0 q=%h r=%h dz=%b",
                     name, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dz);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
        pulse_start(a, b, s, 1'b1);
        finish_op(name, (b == '0) ? 1 : W + 1, 1);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 ||
            bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b required all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        reset = 1'b1;
    endtask

    task automatic test_udiv;
        run_op("udiv_57_8", 64'd57, 64'd8, 1'b0);
        run_op("udiv_max_3", {W{1'b1}}, 64'd3, 1'b0);
        run_op("udiv_small_big", 64'd5, 64'd9, 1'b0);
    endtask

    task automatic test_div_zero;
        run_op("udiv_57_0", 64'd57, 64'd0, 1'b0);
        run_op("sdiv_neg_0", -64'sd12, 64'd0, 1'b1);
        run_op("udiv_after_zero", 64'd10, 64'd2, 1'b0);
    endtask

    task automatic test_sdiv;
        run_op("sdiv_m57_8", -64'sd57, 64'd8, 1'b1);
        run_op("sdiv_57_m8", 64'd57, -64'sd8, 1'b1);
        run_op("sdiv_m57_m8", -64'sd57, -64'sd8, 1'b1);
        run_op("udiv_m57_as_unsigned", -64'sd57, 64'd8, 1'b0);
    endtask

    task automatic test_min_neg;
        run_op("sdiv_min_m1", MIN_NEG, {W{1'b1}}, 1'b1);
        run_op("sdiv_min_2", MIN_NEG, 64'd2, 1'b1);
    endtask

    task automatic test_ignore_start;
        int lat;
        int dones;
        pulse_start(64'd100, 64'd7, 1'b0, 1'b1);
        lat = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            lat++;
        end
        pulse_start(64'd9, 64'd3, 1'b0, 1'b0);
        lat++;
        finish_op("ignore_start", W + 1, lat);
        dones = 0;
        for (int i = 0; i < W + 10; i++) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL ignore_start_extra_done: got %0d extra done pulses required 0", dones);
        end
    endtask

    task automatic test_reset_abort;
        int dones;
        pulse_start(64'd57, 64'd8, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 ||
            bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_state: got busy=%b done=%b q=%h r=%h dz=%b required all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        tick();
        tick();
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < W + 10; i++) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_abort_done: got %0d done pulses required 0", dones);
        end
        run_op("after_abort_9_3", 64'd9, 64'd3, 1'b0);
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom(), $urandom()};
            b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : {$urandom(), $urandom()};
            if (b == '0) b = 64'd1;
            if (i >= 3) b = -b;
            run_op($sformatf("random_%0d", i), a, b, i[0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_udiv();
        test_div_zero();
        test_sdiv();
        test_min_neg();
        test_ignore_start();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i_divide.md
I_DIVIDE -- requirements
Module: i_divide

Interface
REQ-001 Parameter WIDTH, default `WORD (64): operand and result width.
REQ-002 Parameter CNT_W, default 7: iteration counter width, $clog2(WIDTH)+1.
REQ-003 clk  input  1  rising-edge clock, same clk as iFetch.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a division; sampled only in IDLE.
REQ-006 is_signed  input  1  1 = SDIV, 0 = UDIV; captured with start.
REQ-007 dividend  input  WIDTH  read_data1 from iDecode; captured with start.
REQ-008 divisor  input  WIDTH  read_data2 from iDecode; captured with start.
REQ-009 busy  output  1  high while a division is in progress; the fetch stall source.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 quotient  output  WIDTH  result for iWriteBack; held until the next accepted start.
REQ-012 remainder  output  WIDTH  remainder; held with quotient.
REQ-013 div_by_zero  output  1  high with done when the captured divisor was zero; held with the result.

Function
REQ-014 Three states: IDLE, BUSY, DONE; transitions only on rising clk.
REQ-015 IDLE with start=1 and divisor!=0: capture operands and go to BUSY with counter=WIDTH; busy=1 from the next cycle.
REQ-016 IDLE with start=1 and divisor=0: go directly to DONE with quotient=0, remainder=dividend and div_by_zero=1.
REQ-017 BUSY: perform one radix-2 restoring step per cycle on the operand magnitudes and decrement the counter; at counter=1 go to DONE.
REQ-018 Latency: done asserts exactly WIDTH+1 cycles after the start edge for a nonzero divisor, and 1 cycle after for a zero divisor.
REQ-019 DONE: done=1 and busy=0 for one cycle, then unconditionally return to IDLE.
REQ-020 start in BUSY or DONE is ignored; operands are not recaptured.
REQ-021 Unsigned mode: quotient=floor(dividend/divisor) and remainder=dividend-quotient*divisor, with no sign handling.
REQ-022 Signed mode: divide the two's-complement magnitudes; the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend (truncation toward zero).
REQ-023 Signed most-negative value / -1: quotient = most-negative value (wraps), remainder=0, div_by_zero=0.
REQ-024 Magnitude of the most-negative value is handled as WIDTH-bit unsigned 2^(WIDTH-1) without overflow.
REQ-025 quotient, remainder and div_by_zero change only on entry to DONE and stay stable in IDLE.

Reset
REQ-026 While reset=0: state=IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-027 Reset asserted mid-BUSY aborts the operation immediately; no done pulse follows deassertion.
REQ-028 The first start is accepted on the first rising edge after reset deasserts.

Structure
REQ-029 The state enum (IDLE/BUSY/DONE) and the UDIV/SDIV opcode constants belong in the shared CPU definitions package beside `WORD and `INSTR_LEN.
REQ-030 One sub-module, div_step: combinational single restoring step (partial remainder, divisor, next dividend bit -> new partial remainder, quotient bit); instantiated once.
REQ-031 Sign conversion, counter and FSM reside in i_divide; RTL totals 120-400 lines.

Verification
REQ-032 UDIV 57/8, start for 1 cycle -> busy for 64 cycles, done on cycle 65, quotient=7, remainder=1, div_by_zero=0.
REQ-033 UDIV 57/0 -> done 1 cycle after start, quotient=0, remainder=57, div_by_zero=1.
REQ-034 SDIV -57/8 -> quotient=-7, remainder=-1; SDIV 57/-8 -> quotient=-7, remainder=1.
REQ-035 SDIV 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0.
REQ-036 Start 100/7, then start 9/3 pulsed in BUSY cycle 10 -> single done with quotient=14, remainder=2.
REQ-037 Start 57/8, reset=0 in BUSY cycle 20 -> all outputs 0 immediately and no done; a new start of 9/3 -> quotient=3, remainder=0.
